shift_seq_ctrl: RTL

//   Sequencer for the ALU's logical shift datapath: on a start request, loads a 3-bit operand

---
 rtl/shift_seq_ctrl_pkg.sv | 15 +
 rtl/shift_seq_ctrl_if.sv | 28 ++
 rtl/shift_seq_ctrl_shift_reg_lr.sv | 39 +++
 rtl/shift_seq_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants for the shift sequencer: default widths, FSM state codes and shift directions.
package shift_pkg;

    localparam int unsigned DEF_DATA_W = 3;
    localparam int unsigned DEF_OUT_W  = 4;
    localparam int unsigned DEF_AMT_W  = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Front-end/result handshake bundle between the switch/button front end and the shift sequencer.
interface shift_seq_ctrl_if
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned AMT_W  = DEF_AMT_W
);

    logic              init;
    logic [DATA_W-1:0] portA;
    logic [AMT_W-1:0]  amount;
    logic              dir;
    logic [OUT_W-1:0]  result;
    logic              busy;
    logic              done;

    modport master (
        output init, portA, amount, dir,
        input  result, busy, done
    );

    modport slave (
        input  init, portA, amount, dir,
        output result, busy, done
    );

endinterface

// File: rtl/shift_seq_ctrl_shift_reg_lr.sv
// W-bit register with parallel load and a zero-fill single-step left/right shift.
module shift_reg_lr
    import shift_pkg::*;
#(
    parameter int unsigned W = DEF_OUT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_en_i,
    input  logic         dir_i,
    output logic [W-1:0] next_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (shift_en_i) begin
            q_d = (dir_i == DIR_RIGHT) ? (q_q >> 1) : (q_q << 1);
        end
    end

    // The owner captures the value about to be stored so a result can land on the final shift edge.
    assign next_o = q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Counted, handshaked logical-shift sequencer: edge-detected start, N single-bit steps, done pulse.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned AMT_W  = DEF_AMT_W
) (
    input  logic clk,
    input  logic rst,
    shift_seq_ctrl_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             init_q;
    logic [OUT_W-1:0] result_q, result_d;

    logic             start;
    logic             load;
    logic             shift_en;
    logic [OUT_W-1:0] load_val;
    logic [OUT_W-1:0] sh_next;

    assign start    = bus.init & ~init_q & (state_q == S_IDLE);
    assign load_val = {{(OUT_W-DATA_W){1'b0}}, bus.portA};

    shift_reg_lr #(.W(OUT_W)) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .load_val_i(load_val),
        .shift_en_i(shift_en),
        .dir_i     (dir_q),
        .next_o    (sh_next)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        result_d = result_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    cnt_d = bus.amount;
                    dir_d = bus.dir;
                    if (bus.amount != '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d  = S_DONE;
                        result_d = sh_next;
                    end
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q - 1'b1;
                // Result is taken from the value being shifted in, so it moves with done.
                if (cnt_q == AMT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = sh_next;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dir_q    <= DIR_LEFT;
            init_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            init_q   <= bus.init;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);

endmodule
